// File: rtl/seq_wide_adder.sv
// Multi-cycle wide adder/subtractor: processes one cascade_size-bit chunk per
// clock, LSB chunk first, rippling the carry through a register between chunks.
module seq_wide_adder #(
  parameter int cascade_size = 4,
  parameter int chunk_count  = 4
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic                                START,
  input  logic                                SUB,
  input  logic                                C_IN,
  input  logic [cascade_size*chunk_count-1:0] A,
  input  logic [cascade_size*chunk_count-1:0] B,
  output logic [cascade_size*chunk_count-1:0] R,
  output logic                                C_OUT,
  output logic                                OVF,
  output logic                                BUSY,
  output logic                                DONE
);

  localparam int W  = cascade_size * chunk_count;
  localparam int IW = (chunk_count > 1) ? $clog2(chunk_count) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [W-1:0]            r_a;
  logic [W-1:0]            r_b;
  logic [W-1:0]            r_r;
  logic                    r_carry;
  logic                    r_cout;
  logic                    r_ovf;
  logic [IW-1:0]           r_idx;
  logic [31:0]             w_base;
  logic [cascade_size-1:0] w_a_chunk;
  logic [cascade_size-1:0] w_b_chunk;
  logic [cascade_size:0]   w_chunk;
  logic                    w_last;

  assign w_base    = 32'(r_idx) * 32'(cascade_size);
  assign w_a_chunk = r_a[w_base +: cascade_size];
  assign w_b_chunk = r_b[w_base +: cascade_size];
  assign w_chunk   = {1'b0, w_a_chunk} + {1'b0, w_b_chunk}
                   + {{cascade_size{1'b0}}, r_carry};
  assign w_last    = (r_idx == IW'(chunk_count - 1));

  assign R     = r_r;
  assign C_OUT = r_cout;
  assign OVF   = r_ovf;

  always_comb begin
    w_next = r_state;
    BUSY   = 1'b0;
    DONE   = 1'b0;
    case (r_state)
      S_IDLE: if (START) w_next = S_RUN;
      S_RUN: begin
        BUSY = 1'b1;
        if (w_last) w_next = S_FIN;
      end
      S_FIN: begin
        DONE   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Subtraction is folded into the add path: B is inverted and the borrow-in
  // becomes an inverted carry-in, so A + ~B + ~C_IN == A - B - C_IN.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_a     <= A;
            r_b     <= SUB ? ~B : B;
            r_carry <= SUB ? ~C_IN : C_IN;
            r_idx   <= '0;
            r_r     <= '0;
          end
        end
        S_RUN: begin
          r_r[w_base +: cascade_size] <= w_chunk[cascade_size-1:0];
          r_carry                     <= w_chunk[cascade_size];
          if (w_last) begin
            r_cout <= w_chunk[cascade_size];
            // Top bit of the last chunk sum is the final R[W-1].
            r_ovf  <= (r_a[W-1] == r_b[W-1]) &&
                      (w_chunk[cascade_size-1] != r_a[W-1]);
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_wide_adder.sv
// Bench for seq_wide_adder: an arithmetic reference model plus a per-cycle
// checker, driven by directed operand vectors with hand-computed results.
module tb_seq_wide_adder;

  localparam int CS = 4;
  localparam int CC = 4;
  localparam int W  = CS * CC;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         START;
  logic         SUB;
  logic         C_IN;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] R;
  logic         C_OUT;
  logic         OVF;
  logic         BUSY;
  logic         DONE;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int           m_phase = 0;
  logic [W-1:0] m_r     = '0;
  logic         m_c     = 1'b0;
  logic         m_o     = 1'b0;
  logic [W-1:0] m_er    = '0;
  logic         m_ec    = 1'b0;
  logic         m_eo    = 1'b0;

  // Hand-computed expectations for the operation in flight
  logic         lit_valid = 1'b0;
  logic [W-1:0] lit_r     = '0;
  logic         lit_c     = 1'b0;
  logic         lit_o     = 1'b0;

  seq_wide_adder #(.cascade_size(CS), .chunk_count(CC)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .SUB   (SUB),
    .C_IN  (C_IN),
    .A     (A),
    .B     (B),
    .R     (R),
    .C_OUT (C_OUT),
    .OVF   (OVF),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s, input logic ci);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         c;
    logic         o;
    if (!s) begin
      full = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
      c    = full[W];
    end else begin
      full = {1'b0, a} - {1'b0, b} - (W+1)'(ci);
      c    = ~full[W];
    end
    r = full[W-1:0];
    if (!s) o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    else    o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    return {o, c, r};
  endfunction

  // Timeline: phase 1..CC busy, CC+1 done, 0 idle.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_phase = 0;
      m_r     = '0;
      m_c     = 1'b0;
      m_o     = 1'b0;
    end else if (m_phase == 0) begin
      if (START === 1'b1) begin
        {m_eo, m_ec, m_er} = model(A, B, SUB, C_IN);
        m_phase = 1;
        m_r     = '0;
      end
    end else if (m_phase == CC + 1) begin
      m_phase = 0;
    end else begin
      m_phase = m_phase + 1;
      if (m_phase == CC + 1) begin
        m_r = m_er;
        m_c = m_ec;
        m_o = m_eo;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("busy", 32'(BUSY), 32'(m_phase >= 1 && m_phase <= CC));
    chk("done", 32'(DONE), 32'(m_phase == CC + 1));
    if (m_phase == 0 || m_phase == CC + 1) begin
      chk("r", 32'(R), 32'(m_r));
      chk("c_out", 32'(C_OUT), 32'(m_c));
      chk("ovf", 32'(OVF), 32'(m_o));
    end
    if (m_phase == CC + 1 && lit_valid) begin
      chk("lit_r", 32'(R), 32'(lit_r));
      chk("lit_c_out", 32'(C_OUT), 32'(lit_c));
      chk("lit_ovf", 32'(OVF), 32'(lit_o));
      chk("model_vs_lit_r", 32'(m_r), 32'(lit_r));
    end
  end

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                    input logic ci, input logic [W-1:0] er, input logic ec, input logic eo);
    @(negedge CLK); #1;
    lit_valid = 1'b1;
    lit_r = er;
    lit_c = ec;
    lit_o = eo;
    A = a; B = b; SUB = s; C_IN = ci; START = 1'b1;
    @(negedge CLK); #1;
    START = 1'b0;
    // Operands wander while the operation runs; the result must not care.
    repeat (CC + 1) begin
      A    = W'($urandom);
      B    = W'($urandom);
      SUB  = 1'($urandom);
      C_IN = 1'($urandom);
      @(negedge CLK); #1;
    end
    lit_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (DONE) seen = 1'b1;
    end
    #1;
  endtask

  initial begin
    RST_N = 1'b0;
    START = 1'b0;
    SUB   = 1'b0;
    C_IN  = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge CLK);
    #1 RST_N = 1'b1;

    op(16'd10,   16'd20,   1'b0, 1'b0, 16'h001E, 1'b0, 1'b0);
    op(16'h0000, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    op(16'h0001, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    op(16'd5,    16'd7,    1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    op(16'd5,    16'd7,    1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
    op(16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    op(16'h0000, 16'h8000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);

    // START with new operands two cycles into RUN is ignored.
    @(negedge CLK); #1;
    lit_valid = 1'b1; lit_r = 16'h2345; lit_c = 1'b0; lit_o = 1'b0;
    A = 16'h1234; B = 16'h1111; SUB = 1'b0; C_IN = 1'b0; START = 1'b1;
    @(negedge CLK); #1 START = 1'b0;
    @(negedge CLK); #1;
    A = 16'hFFFF; B = 16'hFFFF; SUB = 1'b1; C_IN = 1'b1; START = 1'b1;
    @(negedge CLK); #1 START = 1'b0;
    wait_done();
    // Raised during FIN (ignored), held into the following IDLE cycle (accepted).
    lit_r = 16'h0100; lit_c = 1'b0; lit_o = 1'b0;
    A = 16'h00FF; B = 16'h0001; SUB = 1'b0; C_IN = 1'b0; START = 1'b1;
    @(negedge CLK); #1;
    @(negedge CLK); #1 START = 1'b0;
    wait_done();
    lit_valid = 1'b0;

    // Reset two cycles into RUN aborts with no DONE.
    @(negedge CLK); #1;
    A = 16'h0F0F; B = 16'h0101; SUB = 1'b0; C_IN = 1'b0; START = 1'b1;
    @(negedge CLK); #1 START = 1'b0;
    @(negedge CLK); #2 RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    #1 RST_N = 1'b1;
    op(16'd3, 16'd4, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

    repeat (4) @(negedge CLK);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
